// File: rtl/mult_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mult_pkg                                                         |
// | Shared state encoding and operand-mode constants for the         |
// | sequential shift-add multiplier.                                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pp_gate.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pp_gate                                                          |
// | Partial-product generator: vector AND of i_a with one bit i_bi.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pp_gate #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_bi,
    output logic [WIDTH-1:0] o_pp
);

    assign o_pp = i_a & {WIDTH{i_bi}};

endmodule
`default_nettype wire

// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_shift_add_mult                                               |
// | Radix-2 shift-add multiplier, one partial product per cycle,     |
// | unsigned or two's-complement via sign-magnitude.                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int                c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_p;

    logic                 w_signed;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH-1:0]     w_pp;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;

    // The most negative operand negates to itself, which read as unsigned is its magnitude.
    assign w_signed = (signed_mode == MODE_SIGNED);
    assign w_abs_a  = (w_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    assign w_abs_b  = (w_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

    pp_gate #(
        .WIDTH (WIDTH)
    ) u_pp_gate (
        .i_a  (r_mcand),
        .i_bi (r_mplier[0]),
        .o_pp (w_pp)
    );

    // Add into the upper half, then shift the carry-extended sum down one place.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_pp};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? (~w_acc_next + (2*WIDTH)'(1)) : w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_p      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_cnt_last) begin
                        r_p     <= w_prod;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign P    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seq_shift_add_mult                                            |
// | Scoreboard bench for the shift-add multiplier at WIDTH 16 and 4. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_seq_shift_add_mult;

    localparam int W16 = 16;
    localparam int W4  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s16 = 1'b0, m16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] p16;

    logic        s4 = 1'b0, m4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  p4;

    seq_shift_add_mult #(.WIDTH(W16)) u_dut16 (
        .clk(clk), .rst(rst), .start(s16), .signed_mode(m16),
        .A(a16), .B(b16), .busy(busy16), .done(done16), .P(p16)
    );

    seq_shift_add_mult #(.WIDTH(W4)) u_dut4 (
        .clk(clk), .rst(rst), .start(s4), .signed_mode(m4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .P(p4)
    );

    always #5 clk = ~clk;

    int unsigned ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        logic [63:0] p;
        int unsigned due;
    } exp_t;

    exp_t        q16[$];
    exp_t        q4[$];
    int unsigned ready16 = 0, ready4 = 0;
    logic [63:0] held16 = '0, held4 = '0;
    bit          mon_en = 1'b0;
    int          n_cmp = 0, n_bad = 0;
    logic        e_done16, e_busy16, e_done4, e_busy4;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, ecount, act, exp);
        end
    endtask

    // Reference: plain integer product of the operands as read in the selected mode.
    function automatic logic [63:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic m, input int w);
        longint va, vb, prod;
        logic [63:0] mask;
        va = longint'(a) & ((longint'(1) << w) - 1);
        vb = longint'(b) & ((longint'(1) << w) - 1);
        if (m && a[w-1]) va = va - (longint'(1) << w);
        if (m && b[w-1]) vb = vb - (longint'(1) << w);
        prod = va * vb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(prod) & mask;
    endfunction

    // Issue one start cycle; the model accepts it only once the previous op has reached DONE.
    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic m);
        a16 = a; b16 = b; m16 = m; s16 = 1'b1;
        if (ecount >= ready16) begin
            q16.push_back('{p: ref_mul(a, b, m, W16), due: ecount + W16 + 1});
            ready16 = ecount + W16 + 1;
        end
        @(negedge clk);
        s16 = 1'b0;
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic m);
        a4 = a; b4 = b; m4 = m; s4 = 1'b1;
        if (ecount >= ready4) begin
            q4.push_back('{p: ref_mul({12'd0, a}, {12'd0, b}, m, W4), due: ecount + W4 + 1});
            ready4 = ecount + W4 + 1;
        end
        @(negedge clk);
        s4 = 1'b0;
    endtask

    task automatic idle16();
        while (ecount < ready16) @(negedge clk);
    endtask

    task automatic idle4();
        while (ecount < ready4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            e_done16 = (q16.size() > 0) && (ecount == q16[0].due);
            e_busy16 = (q16.size() > 0) && (ecount + W16 >= q16[0].due) && (ecount < q16[0].due);
            chk("busy16", busy16, e_busy16);
            chk("done16", done16, e_done16);
            if (e_done16) begin
                chk("P16", p16, q16[0].p);
                held16 = q16[0].p;
                void'(q16.pop_front());
            end else begin
                chk("P16_hold", p16, held16);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            e_done4 = (q4.size() > 0) && (ecount == q4[0].due);
            e_busy4 = (q4.size() > 0) && (ecount + W4 >= q4[0].due) && (ecount < q4[0].due);
            chk("busy4", busy4, e_busy4);
            chk("done4", done4, e_done4);
            if (e_done4) begin
                chk("P4", p4, q4[0].p);
                held4 = q4[0].p;
                void'(q4.pop_front());
            end else begin
                chk("P4_hold", p4, held4);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] da[6];
        logic [15:0] db[6];
        logic        dm[6];
        da = '{16'h0003, 16'hFFFF, 16'hFFFF, 16'h8000, 16'hFFFD, 16'h8000};
        db = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0005, 16'h0001};
        dm = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy16", busy16, 1'b0);
        chk("rst_done16", done16, 1'b0);
        chk("rst_P16", p16, 32'd0);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_done4", done4, 1'b0);
        chk("rst_P4", p4, 8'd0);
        rst = 1'b0;
        ready16 = ecount;
        ready4  = ecount;
        mon_en  = 1'b1;

        for (int i = 0; i < 6; i++) begin
            idle16();
            go16(da[i], db[i], dm[i]);
        end
        idle16();

        // Start during busy is ignored; start held in the DONE cycle chains a new op.
        go16(16'h0003, 16'h0005, 1'b0);
        repeat (4) @(negedge clk);
        go16(16'h1234, 16'h5678, 1'b0);
        idle16();
        go16(16'h00FF, 16'h0101, 1'b0);
        idle16();

        // Mid-run reset with a simultaneous start: abort, no done, start discarded.
        go16(16'h0007, 16'h0009, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1; s16 = 1'b1; a16 = 16'h00AA; b16 = 16'h0055;
        @(negedge clk);
        rst = 1'b0; s16 = 1'b0;
        q16.delete(); q4.delete();
        held16 = '0; held4 = '0;
        ready16 = ecount; ready4 = ecount;
        go16(16'hFFFD, 16'h0005, 1'b1);
        idle16();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                while (ecount < ready16) begin
                    a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom);
                    @(negedge clk);
                end
            end
            go16(16'($urandom), 16'($urandom), 1'($urandom));
        end
        idle16();

        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    idle4();
                    go4(4'(a), 4'(b), 1'(m));
                end
        idle4();
        repeat (3) @(negedge clk);
        #3;
        chk("q16_drained", 64'(q16.size()), 64'd0);
        chk("q4_drained", 64'(q4.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
